// File: rtl/player_pkg.sv
// Shared types for the player-ship controller: FSM state encoding and colour layout.
package player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DEAD   = 3'd4
    } player_state_e;

    typedef logic [11:0] color_t;

    localparam int COLOR_R_MSB = 11;
    localparam int COLOR_R_LSB = 8;
    localparam int COLOR_G_MSB = 7;
    localparam int COLOR_G_LSB = 4;
    localparam int COLOR_B_MSB = 3;
    localparam int COLOR_B_LSB = 0;

    function automatic logic is_alive(input player_state_e s);
        return (s == ST_IDLE) || (s == ST_LEFT) || (s == ST_RIGHT);
    endfunction

endpackage

// File: rtl/player_pos_ctrl.sv
// Ship position register with movement prescaler and border clamping.
module player_pos_ctrl #(
    parameter int pos_width_p   = 10,
    parameter int ship_width_p  = 40,
    parameter int step_p        = 10,
    parameter int left_border_p = 9,
    parameter int right_border_p = 630,
    parameter int reset_pos_p   = 249,
    parameter int move_div_p    = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   move_left_i,
    input  logic                   move_right_i,
    input  logic                   reload_i,
    output logic [pos_width_p-1:0] pos_left_o
);

    localparam int DIV_W = (move_div_p > 1) ? $clog2(move_div_p) : 1;
    localparam int PW1   = pos_width_p + 1;

    localparam logic [DIV_W-1:0]       DIV_LOAD   = DIV_W'(move_div_p - 1);
    localparam logic [PW1-1:0]         STEP       = PW1'(step_p);
    localparam logic [PW1-1:0]         LEFT_MIN   = PW1'(left_border_p);
    localparam logic [PW1-1:0]         LEFT_LIMIT = PW1'(left_border_p + step_p);
    localparam logic [PW1-1:0]         RIGHT_MAX  = PW1'(right_border_p - ship_width_p);
    localparam logic [pos_width_p-1:0] RESET_POS  = pos_width_p'(reset_pos_p);

    logic [DIV_W-1:0]       div_q;
    logic [pos_width_p-1:0] pos_q;
    logic [PW1-1:0]         pos_ext;
    logic [PW1-1:0]         pos_sum;
    logic [PW1-1:0]         pos_next;
    logic                   moving;
    logic                   tick;

    assign moving  = move_left_i | move_right_i;
    assign tick    = moving && (div_q == '0);
    assign pos_ext = {1'b0, pos_q};
    assign pos_sum = pos_ext + STEP;

    // Extra bit on pos_ext keeps the subtract/add clamps free of wraparound.
    always_comb begin
        pos_next = pos_ext;
        if (move_left_i) begin
            pos_next = (pos_ext >= LEFT_LIMIT) ? (pos_ext - STEP) : LEFT_MIN;
        end else if (move_right_i) begin
            pos_next = (pos_sum > RIGHT_MAX) ? RIGHT_MAX : pos_sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= DIV_LOAD;
            pos_q <= RESET_POS;
        end else begin
            if (!moving || div_q == '0) begin
                div_q <= DIV_LOAD;
            end else begin
                div_q <= div_q - DIV_W'(1);
            end

            if (reload_i) begin
                pos_q <= RESET_POS;
            end else if (tick) begin
                pos_q <= pos_next[pos_width_p-1:0];
            end
        end
    end

    assign pos_left_o = pos_q;

endmodule

// File: rtl/player_ship_ctrl.sv
// Player-ship controller: movement FSM, lives, fire limiter and pause/death flow.
// Optional PLAYER_INVULN_EN adds a post-resume invulnerability window (invuln_o).
//
// state  | meaning
// IDLE   | alive, not moving
// LEFT   | alive, stepping left on prescaler ticks
// RIGHT  | alive, stepping right on prescaler ticks
// PAUSED | hit with lives left; frozen until shoot edge
// DEAD   | hit with no lives; shoot edge starts a new game
module player_ship_ctrl
    import player_pkg::*;
#(
    parameter int     pos_width_p     = 10,
    parameter int     ship_width_p    = 40,
    parameter int     step_p          = 10,
    parameter int     left_border_p   = 9,
    parameter int     right_border_p  = 630,
    parameter int     reset_pos_p     = 249,
    parameter int     move_div_p      = 4,
    parameter int     lives_width_p   = 2,
    parameter int     max_lives_p     = 3,
    parameter int     init_lives_p    = 2,
    parameter int     fire_cooldown_p = 8,
    parameter color_t color_p         = 12'h5E5
`ifdef PLAYER_INVULN_EN
    ,parameter int    invuln_cycles_p = 120
`endif
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     move_left_i,
    input  logic                     move_right_i,
    input  logic                     shoot_i,
    input  logic                     hit_i,
    input  logic                     add_life_i,
    output logic                     alive_o,
    output logic [lives_width_p-1:0] lives_o,
    output logic                     shot_laser_o,
    output logic                     resume_o,
    output logic                     new_game_o,
    output logic [pos_width_p-1:0]   pos_left_o,
    output logic [pos_width_p-1:0]   pos_right_o,
    output logic [pos_width_p-1:0]   gun_pos_o,
    output logic [3:0]               player_red_o,
    output logic [3:0]               player_green_o,
    output logic [3:0]               player_blue_o,
    output logic [2:0]               state_o
`ifdef PLAYER_INVULN_EN
    ,output logic                    invuln_o
`endif
);

    localparam int LW1  = lives_width_p + 1;
    localparam int CD_W = $clog2(fire_cooldown_p + 1);

    localparam logic [LW1-1:0]           MAX_LIVES  = LW1'(max_lives_p);
    localparam logic [lives_width_p-1:0] INIT_LIVES = lives_width_p'(init_lives_p);
    localparam logic [CD_W-1:0]          CD_LOAD    = CD_W'(fire_cooldown_p);

    player_state_e            state_q, state_d;
    logic [lives_width_p-1:0] lives_q, lives_d;
    logic [CD_W-1:0]          cool_q;
    logic [LW1-1:0]           lives_sum;
    logic [LW1-1:0]           lives_eff;
    logic                     shoot_q;
    logic                     shoot_rise;
    logic                     hit_eff;
    logic                     fire_d;
    logic                     reload;
    logic                     resume_d;
    logic                     new_game_d;
    logic                     shot_q;
    logic                     resume_q;
    logic                     new_game_q;

    assign shoot_rise = shoot_i & ~shoot_q;
    assign lives_sum  = {1'b0, lives_q} + LW1'(add_life_i);
    assign lives_eff  = (lives_sum > MAX_LIVES) ? MAX_LIVES : lives_sum;

`ifdef PLAYER_INVULN_EN
    localparam int IV_W = $clog2(invuln_cycles_p + 1);
    localparam logic [IV_W-1:0] IV_LOAD = IV_W'(invuln_cycles_p);

    logic [IV_W-1:0] invuln_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            invuln_q <= '0;
        end else if (resume_d) begin
            invuln_q <= IV_LOAD;
        end else if (invuln_q != '0) begin
            invuln_q <= invuln_q - IV_W'(1);
        end
    end

    assign invuln_o = (invuln_q != '0);
    assign hit_eff  = hit_i & ~invuln_o;
`else
    assign hit_eff  = hit_i;
`endif

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        reload     = 1'b0;
        resume_d   = 1'b0;
        new_game_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_LEFT, ST_RIGHT: begin
                if (hit_eff) begin
                    if (lives_eff != '0) begin
                        lives_d = lives_eff[lives_width_p-1:0] - lives_width_p'(1);
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_DEAD;
                    end
                end else begin
                    lives_d = lives_eff[lives_width_p-1:0];
                    if (move_left_i && !move_right_i) begin
                        state_d = ST_LEFT;
                    end else if (move_right_i && !move_left_i) begin
                        state_d = ST_RIGHT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PAUSED: begin
                if (shoot_rise) begin
                    state_d  = ST_IDLE;
                    reload   = 1'b1;
                    resume_d = 1'b1;
                end
            end
            ST_DEAD: begin
                if (shoot_rise) begin
                    state_d    = ST_IDLE;
                    reload     = 1'b1;
                    resume_d   = 1'b1;
                    new_game_d = 1'b1;
                    lives_d    = INIT_LIVES;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A hit in the same cycle as the shoot edge wins; no bullet leaves a dying ship.
    assign fire_d = shoot_rise && is_alive(state_q) && !hit_eff && (cool_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            lives_q    <= INIT_LIVES;
            cool_q     <= '0;
            shoot_q    <= 1'b1;
            shot_q     <= 1'b0;
            resume_q   <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            shoot_q    <= shoot_i;
            shot_q     <= fire_d;
            resume_q   <= resume_d;
            new_game_q <= new_game_d;
            if (resume_d) begin
                cool_q <= '0;
            end else if (fire_d) begin
                cool_q <= CD_LOAD;
            end else if (cool_q != '0) begin
                cool_q <= cool_q - CD_W'(1);
            end
        end
    end

    player_pos_ctrl #(
        .pos_width_p   (pos_width_p),
        .ship_width_p  (ship_width_p),
        .step_p        (step_p),
        .left_border_p (left_border_p),
        .right_border_p(right_border_p),
        .reset_pos_p   (reset_pos_p),
        .move_div_p    (move_div_p)
    ) u_pos (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .move_left_i (state_q == ST_LEFT),
        .move_right_i(state_q == ST_RIGHT),
        .reload_i    (reload),
        .pos_left_o  (pos_left_o)
    );

    assign pos_right_o    = pos_left_o + pos_width_p'(ship_width_p);
    assign gun_pos_o      = pos_left_o + pos_width_p'(ship_width_p / 2);
    assign alive_o        = (state_q != ST_DEAD);
    assign lives_o        = lives_q;
    assign shot_laser_o   = shot_q;
    assign resume_o       = resume_q;
    assign new_game_o     = new_game_q;
    assign state_o        = state_q;
    assign player_red_o   = color_p[COLOR_R_MSB:COLOR_R_LSB];
    assign player_green_o = color_p[COLOR_G_MSB:COLOR_G_LSB];
    assign player_blue_o  = color_p[COLOR_B_MSB:COLOR_B_LSB];

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Directed self-checking bench for player_ship_ctrl with default parameters.
module tb_player_ship_ctrl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       move_left_i = 1'b0;
    logic       move_right_i = 1'b0;
    logic       shoot_i = 1'b0;
    logic       hit_i = 1'b0;
    logic       add_life_i = 1'b0;
    logic       alive_o;
    logic [1:0] lives_o;
    logic       shot_laser_o;
    logic       resume_o;
    logic       new_game_o;
    logic [9:0] pos_left_o;
    logic [9:0] pos_right_o;
    logic [9:0] gun_pos_o;
    logic [3:0] player_red_o;
    logic [3:0] player_green_o;
    logic [3:0] player_blue_o;
    logic [2:0] state_o;
`ifdef PLAYER_INVULN_EN
    logic       invuln_o;
`endif

    int checks = 0;
    int failures = 0;
    logic over_border;

    always #5 clk = ~clk;

    player_ship_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .move_left_i   (move_left_i),
        .move_right_i  (move_right_i),
        .shoot_i       (shoot_i),
        .hit_i         (hit_i),
        .add_life_i    (add_life_i),
        .alive_o       (alive_o),
        .lives_o       (lives_o),
        .shot_laser_o  (shot_laser_o),
        .resume_o      (resume_o),
        .new_game_o    (new_game_o),
        .pos_left_o    (pos_left_o),
        .pos_right_o   (pos_right_o),
        .gun_pos_o     (gun_pos_o),
        .player_red_o  (player_red_o),
        .player_green_o(player_green_o),
        .player_blue_o (player_blue_o),
        .state_o       (state_o)
`ifdef PLAYER_INVULN_EN
        ,.invuln_o     (invuln_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic post_resume();
`ifdef PLAYER_INVULN_EN
        tick(121);
`endif
    endtask

    task automatic resume_seq();
        shoot_i = 1'b1; tick();
        shoot_i = 1'b0; tick();
        post_resume();
    endtask

    initial begin
        tick(2);
        reset_i = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_pos_left", pos_left_o, 249);
        chk("rst_pos_right", pos_right_o, 289);
        chk("rst_gun", gun_pos_o, 269);
        chk("rst_lives", lives_o, 2);
        chk("rst_alive", alive_o, 1);
        chk("rst_pulses", {shot_laser_o, resume_o, new_game_o}, 0);
        chk("color", {player_red_o, player_green_o, player_blue_o}, 12'h5E5);

        // left sweep: first step 4 cycles after entering LEFT, clamp at 9
        move_left_i = 1'b1;
        tick();
        chk("left_enter", state_o, 1);
        tick(3);
        chk("left_pre_step", pos_left_o, 249);
        tick();
        chk("left_step1", pos_left_o, 239);
        tick(4);
        chk("left_step2", pos_left_o, 229);
        tick(100);
        chk("left_clamp", pos_left_o, 9);
        chk("left_clamp_gun", gun_pos_o, 29);
        chk("left_clamp_right", pos_right_o, 49);
        tick(8);
        chk("left_clamp_hold", pos_left_o, 9);
        move_left_i = 1'b0;
        tick();
        chk("left_release", state_o, 0);

        // right sweep from reset position, never beyond 590/630
        reset_i = 1'b1; tick();
        reset_i = 1'b0;
        chk("rst2_pos", pos_left_o, 249);
        move_right_i = 1'b1;
        over_border = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pos_right_o > 630 || pos_left_o > 590) over_border = 1'b1;
        end
        chk("right_no_overshoot", over_border, 0);
        chk("right_clamp_left", pos_left_o, 590);
        chk("right_clamp_right", pos_right_o, 630);
        chk("right_state", state_o, 2);
        move_right_i = 1'b0;
        tick();
        chk("right_release", state_o, 0);

        // fire limiter: edge at 0 fires, +3 blocked, +9 fires
        shoot_i = 1'b1; tick();
        chk("shot_first", shot_laser_o, 1);
        shoot_i = 1'b0; tick();
        chk("shot_one_cycle", shot_laser_o, 0);
        tick();
        shoot_i = 1'b1; tick();
        chk("shot_cooldown_block", shot_laser_o, 0);
        shoot_i = 1'b0; tick(5);
        shoot_i = 1'b1; tick();
        chk("shot_after_cooldown", shot_laser_o, 1);
        shoot_i = 1'b0; tick();
        chk("shot_after_cooldown_end", shot_laser_o, 0);

        // hit with 2 lives -> PAUSED, frozen, add_life ignored, resume
        hit_i = 1'b1; tick();
        hit_i = 1'b0;
        chk("hit_paused", state_o, 3);
        chk("hit_lives", lives_o, 1);
        move_left_i = 1'b1; add_life_i = 1'b1; tick();
        add_life_i = 1'b0; tick(6);
        chk("paused_frozen", pos_left_o, 590);
        chk("paused_no_bonus", lives_o, 1);
        chk("paused_hold", state_o, 3);
        move_left_i = 1'b0;
        shoot_i = 1'b1; tick();
        chk("resume_state", state_o, 0);
        chk("resume_pulse", resume_o, 1);
        chk("resume_no_newgame", new_game_o, 0);
        chk("resume_pos", pos_left_o, 249);
        chk("resume_no_shot", shot_laser_o, 0);
        shoot_i = 1'b0; tick();
        chk("resume_pulse_end", resume_o, 0);
        chk("resume_no_shot2", shot_laser_o, 0);
`ifdef PLAYER_INVULN_EN
        chk("invuln_on", invuln_o, 1);
        hit_i = 1'b1; tick();
        hit_i = 1'b0;
        chk("invuln_hit_ignored", state_o, 0);
        chk("invuln_lives", lives_o, 1);
`endif
        post_resume();

        // bonus lives saturate at 3; hit+bonus at 3 lands on 2
        add_life_i = 1'b1; tick();
        add_life_i = 1'b0;
        chk("bonus_add", lives_o, 2);
        add_life_i = 1'b1; tick(2);
        add_life_i = 1'b0;
        chk("bonus_saturate", lives_o, 3);
        hit_i = 1'b1; add_life_i = 1'b1; tick();
        hit_i = 1'b0; add_life_i = 1'b0;
        chk("hit_bonus_sat_lives", lives_o, 2);
        chk("hit_bonus_sat_state", state_o, 3);
        resume_seq();

        hit_i = 1'b1; tick(); hit_i = 1'b0;
        chk("hit_to_1", lives_o, 1);
        resume_seq();
        hit_i = 1'b1; tick(); hit_i = 1'b0;
        chk("hit_to_0", lives_o, 0);
        resume_seq();

        // lives 0, hit with bonus in the same cycle -> PAUSED with 0
        hit_i = 1'b1; add_life_i = 1'b1; tick();
        hit_i = 1'b0; add_life_i = 1'b0;
        chk("zero_hit_bonus_state", state_o, 3);
        chk("zero_hit_bonus_lives", lives_o, 0);
        resume_seq();

        // lives 0 plus hit -> DEAD, then new game
        hit_i = 1'b1; tick(); hit_i = 1'b0;
        chk("dead_state", state_o, 4);
        chk("dead_alive", alive_o, 0);
        shoot_i = 1'b1; tick();
        chk("newgame_pulse", new_game_o, 1);
        chk("newgame_resume", resume_o, 1);
        chk("newgame_lives", lives_o, 2);
        chk("newgame_state", state_o, 0);
        chk("newgame_alive", alive_o, 1);
        shoot_i = 1'b0; tick();
        chk("newgame_pulse_end", new_game_o, 0);
        post_resume();

        // reset mid-move in RIGHT with lives altered
        hit_i = 1'b1; tick(); hit_i = 1'b0;
        resume_seq();
        chk("pre_reset_lives", lives_o, 1);
        move_right_i = 1'b1;
        tick(10);
        chk("mid_move_state", state_o, 2);
        chk("mid_move_pos", pos_left_o, 269);
        reset_i = 1'b1; tick();
        chk("midrst_state", state_o, 0);
        chk("midrst_pos", pos_left_o, 249);
        chk("midrst_lives", lives_o, 2);
        chk("midrst_pulses", {shot_laser_o, resume_o, new_game_o}, 0);
        chk("midrst_alive", alive_o, 1);
        move_right_i = 1'b0;
        reset_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
